// File: rtl/ap_tag_sequencer.sv
// Initiator side of the associative-processor cell-column interface: broadcasts a
// compare command to the bit-columns, reduces the per-cell tags per row, then runs a write pass.
module ap_tag_sequencer #(
   parameter int unsigned DATA_DEPTH = 4,
   parameter int unsigned NUM_COLS   = 8,
   localparam int unsigned IdxW      = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
   input  logic                           clk,
   input  logic                           rst_In,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [NUM_COLS-1:0]            cmd_key,
   input  logic [NUM_COLS-1:0]            cmd_mask,
   input  logic [2:0]                     cmd_pass,
   input  logic                           cmd_abs,
   output logic [NUM_COLS-1:0]            cell_key,
   output logic [NUM_COLS-1:0]            cell_mask,
   output logic [2:0]                     cell_pass,
   output logic                           cell_abs_opt,
   output logic [DATA_DEPTH-1:0]          cell_tag,
   input  logic [NUM_COLS*DATA_DEPTH-1:0] tag_cell_in,
   output logic [DATA_DEPTH-1:0]          tag_out,
   output logic                           match_any,
   output logic [IdxW-1:0]                match_first,
   output logic                           done
);

   typedef enum logic [1:0] {StIdle, StCmp, StWr, StDone} state_e;

   state_e                state_q;
   logic [2:0]            pass_q;
   logic                  abs_q;
   logic [DATA_DEPTH-1:0] tag_d;
   logic [IdxW-1:0]       first_d;

   // Ready is gated by reset directly so no command can be offered while it is held.
   assign cmd_ready = (state_q == StIdle) & ~rst_In;
   assign cell_tag  = tag_out;

   // Masked columns return 1, so a plain AND across columns gives the row tag.
   always_comb begin
      tag_d = '1;
      for (int c = 0; c < int'(NUM_COLS); c++) begin
         for (int r = 0; r < int'(DATA_DEPTH); r++) begin
            tag_d[r] = tag_d[r] & tag_cell_in[c*int'(DATA_DEPTH)+r];
         end
      end
   end

   always_comb begin
      first_d = '0;
      for (int r = int'(DATA_DEPTH) - 1; r >= 0; r--) begin
         if (tag_d[r]) first_d = IdxW'(r);
      end
   end

   always_ff @(posedge clk or posedge rst_In) begin
      if (rst_In) begin
         state_q      <= StIdle;
         pass_q       <= '0;
         abs_q        <= 1'b0;
         cell_key     <= '0;
         cell_mask    <= '0;
         cell_pass    <= '0;
         cell_abs_opt <= 1'b0;
         tag_out      <= '0;
         match_any    <= 1'b0;
         match_first  <= '0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  cell_key  <= cmd_key;
                  cell_mask <= cmd_mask;
                  pass_q    <= cmd_pass;
                  abs_q     <= cmd_abs;
                  state_q   <= StCmp;
               end
            end
            StCmp: begin
               tag_out     <= tag_d;
               match_any   <= |tag_d;
               match_first <= first_d;
               if (pass_q != 3'd0) begin
                  cell_pass    <= pass_q;
                  cell_abs_opt <= abs_q;
                  state_q      <= StWr;
               end else begin
                  done    <= 1'b1;
                  state_q <= StDone;
               end
            end
            StWr: begin
               cell_pass    <= '0;
               cell_abs_opt <= 1'b0;
               done         <= 1'b1;
               state_q      <= StDone;
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ap_tag_sequencer.sv
// Directed bench for ap_tag_sequencer with a small 4x8 cell-array model
// (compare per cell, pass 3 inverts tagged rows).
module tb_ap_tag_sequencer;

   logic        clk;
   logic        rst_In;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_key;
   logic [7:0]  cmd_mask;
   logic [2:0]  cmd_pass;
   logic        cmd_abs;
   logic [7:0]  cell_key;
   logic [7:0]  cell_mask;
   logic [2:0]  cell_pass;
   logic        cell_abs_opt;
   logic [3:0]  cell_tag;
   logic [31:0] tag_cell_in;
   logic [3:0]  tag_out;
   logic        match_any;
   logic [1:0]  match_first;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mem [4] = '{8'h00, 8'hA5, 8'h5A, 8'hA5};

   ap_tag_sequencer #(.DATA_DEPTH(4), .NUM_COLS(8)) dut (
      .clk          (clk),
      .rst_In       (rst_In),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_key      (cmd_key),
      .cmd_mask     (cmd_mask),
      .cmd_pass     (cmd_pass),
      .cmd_abs      (cmd_abs),
      .cell_key     (cell_key),
      .cell_mask    (cell_mask),
      .cell_pass    (cell_pass),
      .cell_abs_opt (cell_abs_opt),
      .cell_tag     (cell_tag),
      .tag_cell_in  (tag_cell_in),
      .tag_out      (tag_out),
      .match_any    (match_any),
      .match_first  (match_first),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cell model: each cell compares its stored bit against the key when its column is enabled.
   always_comb begin
      tag_cell_in = '1;
      for (int c = 0; c < 8; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (cell_mask[c]) tag_cell_in[c*4+r] = (mem[r][c] == cell_key[c]);
         end
      end
   end

   always @(posedge clk) begin
      if (cell_pass == 3'd3) begin
         for (int r = 0; r < 4; r++) begin
            if (cell_tag[r]) mem[r] <= ~mem[r];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a command for one edge; returns 1 ns after the accept edge (state CMP).
   task automatic issue(input logic [7:0] k, input logic [7:0] m, input logic [2:0] p,
                        input logic a);
      cmd_key   = k;
      cmd_mask  = m;
      cmd_pass  = p;
      cmd_abs   = a;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst_In    = 1'b1;
      cmd_valid = 1'b0;
      cmd_key   = '0;
      cmd_mask  = '0;
      cmd_pass  = '0;
      cmd_abs   = 1'b0;
      #2;
      chk("rst_ready", cmd_ready, 0);
      chk("rst_pass", cell_pass, 0);
      chk("rst_tag", tag_out, 0);
      chk("rst_done", done, 0);
      tick();
      tick();
      @(negedge clk);
      rst_In = 1'b0;
      tick();
      chk("idle_ready", cmd_ready, 1);

      // Compare only, full mask
      issue(8'hA5, 8'hFF, 3'd0, 1'b0);
      chk("c_cmp_ready", cmd_ready, 0);
      chk("c_cmp_done", done, 0);
      chk("c_cmp_key", cell_key, 8'hA5);
      tick();
      chk("c_done", done, 1);
      chk("c_tag", tag_out, 4'b1010);
      chk("c_any", match_any, 1);
      chk("c_first", match_first, 1);
      chk("c_pass", cell_pass, 0);
      tick();
      chk("c_idle_done", done, 0);
      chk("c_idle_ready", cmd_ready, 1);

      // Write pass 3 on bit 0 match
      issue(8'hA5, 8'h01, 3'd3, 1'b0);
      chk("w_cmp_pass", cell_pass, 0);
      chk("w_cmp_mask", cell_mask, 8'h01);
      tick();
      chk("w_wr_pass", cell_pass, 3);
      chk("w_wr_tag", cell_tag, 4'b1010);
      chk("w_wr_done", done, 0);
      tick();
      chk("w_done", done, 1);
      chk("w_done_pass", cell_pass, 0);
      chk("w_mem0", mem[0], 8'h00);
      chk("w_mem1", mem[1], 8'h5A);
      chk("w_mem2", mem[2], 8'h5A);
      chk("w_mem3", mem[3], 8'h5A);
      tick();

      // No match, write pass still runs with an empty tag
      issue(8'hFF, 8'hFF, 3'd3, 1'b0);
      tick();
      chk("n_tag", tag_out, 0);
      chk("n_any", match_any, 0);
      chk("n_first", match_first, 0);
      chk("n_wr_pass", cell_pass, 3);
      chk("n_wr_tag", cell_tag, 0);
      tick();
      chk("n_done", done, 1);
      chk("n_mem1", mem[1], 8'h5A);
      chk("n_mem0", mem[0], 8'h00);
      tick();

      // All-masked command with cmd_valid held through DONE
      cmd_key   = 8'h00;
      cmd_mask  = 8'h00;
      cmd_pass  = 3'd0;
      cmd_valid = 1'b1;
      tick();
      chk("m_cmp_ready", cmd_ready, 0);
      cmd_key  = 8'h5A;
      cmd_mask = 8'hFF;
      tick();
      chk("m_done", done, 1);
      chk("m_tag", tag_out, 4'b1111);
      chk("m_first", match_first, 0);
      chk("m_any", match_any, 1);
      chk("m_done_ready", cmd_ready, 0);
      tick();
      chk("m_idle_ready", cmd_ready, 1);
      chk("m_idle_done", done, 0);
      tick();
      cmd_valid = 1'b0;
      chk("m2_cmp_ready", cmd_ready, 0);
      chk("m2_cmp_key", cell_key, 8'h5A);
      tick();
      chk("m2_done", done, 1);
      chk("m2_tag", tag_out, 4'b1110);
      chk("m2_first", match_first, 1);
      tick();

      // Reset asserted in the middle of a write pass
      issue(8'h5A, 8'hFF, 3'd3, 1'b1);
      tick();
      chk("r_wr_pass", cell_pass, 3);
      chk("r_wr_abs", cell_abs_opt, 1);
      #2;
      rst_In = 1'b1;
      #1;
      chk("r_pass", cell_pass, 0);
      chk("r_abs", cell_abs_opt, 0);
      chk("r_ready", cmd_ready, 0);
      chk("r_tag", tag_out, 0);
      chk("r_any", match_any, 0);
      chk("r_key", cell_key, 0);
      chk("r_done", done, 0);
      tick();
      chk("r_hold_ready", cmd_ready, 0);
      chk("r_mem1", mem[1], 8'h5A);
      chk("r_mem3", mem[3], 8'h5A);
      @(negedge clk);
      rst_In = 1'b0;
      #1;
      chk("r_rel_ready", cmd_ready, 1);
      tick();
      chk("r_idle_ready", cmd_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
